// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the first key seen
// and reports its code, tracking that single key until it is stably released.
module keypad_scan_4x4 #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DbW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHold,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        row_meta_q, row_s_q;
    logic [DivW-1:0]   div_q, div_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [DbW-1:0]    db_cnt_q, db_cnt_d;
    logic [3:0]        col_q, col_d;
    logic [3:0]        key_value_q, key_value_d;
    logic              key_valid_q, key_valid_d;
    logic              key_pressed_q, key_pressed_d;
    logic              tick;
    logic              tracked_high;
    logic [1:0]        low_idx;

    assign tick         = (div_q == DivLast);
    assign div_d        = tick ? '0 : div_q + 1'b1;
    assign tracked_high = row_s_q[row_idx_q];

    // Lowest-numbered pressed row wins when several are low together.
    always_comb begin
        low_idx = 2'd3;
        if (!row_s_q[0]) begin
            low_idx = 2'd0;
        end else if (!row_s_q[1]) begin
            low_idx = 2'd1;
        end else if (!row_s_q[2]) begin
            low_idx = 2'd2;
        end
    end

    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        db_cnt_d      = db_cnt_q;
        key_value_d   = key_value_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (row_s_q == 4'b1111) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = low_idx;
                        db_cnt_d  = '0;
                        state_d   = StDebounce;
                    end
                end
                StDebounce: begin
                    if (!tracked_high) begin
                        if (db_cnt_q == DbLast) begin
                            state_d       = StHold;
                            key_value_d   = {row_idx_q, col_idx_q};
                            key_valid_d   = 1'b1;
                            key_pressed_d = 1'b1;
                        end else begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = StScan;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                StHold: begin
                    if (tracked_high) begin
                        db_cnt_d = '0;
                        state_d  = StRelease;
                    end
                end
                StRelease: begin
                    if (tracked_high) begin
                        if (db_cnt_q == DbLast) begin
                            state_d       = StScan;
                            key_pressed_d = 1'b0;
                            col_idx_d     = col_idx_q + 2'd1;
                        end else begin
                            db_cnt_d = db_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = StHold;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    // Column drive is registered from the next index so col never glitches.
    assign col_d = ~(4'b0001 << col_idx_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StScan;
            row_meta_q    <= 4'b1111;
            row_s_q       <= 4'b1111;
            div_q         <= '0;
            col_idx_q     <= 2'd0;
            row_idx_q     <= 2'd0;
            db_cnt_q      <= '0;
            col_q         <= 4'b1110;
            key_value_q   <= 4'h0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_meta_q    <= row;
            row_s_q       <= row_meta_q;
            div_q         <= div_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            db_cnt_q      <= db_cnt_d;
            col_q         <= col_d;
            key_value_q   <= key_value_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign col         = col_q;
    assign key_value   = key_value_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Self-checking bench for keypad_scan_4x4: a keypad matrix model drives row from col, and a
// tick-level behavioural model predicts every output each cycle alongside directed checks.
module tb_keypad_scan_4x4;

    localparam int ScanDiv  = 4;
    localparam int Debounce = 3;

    logic        clk;
    logic        reset_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_value;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    // Behavioural model state: phase 0 idle, 1 confirming press, 2 held, 3 confirming release.
    int         m_cyc, m_phase, m_col, m_row, m_streak, m_ticks;
    logic [3:0] m_value;
    logic       m_valid, m_pressed;
    logic [3:0] hist[$];

    keypad_scan_4x4 #(
        .SCAN_DIV(ScanDiv),
        .DEBOUNCE(Debounce)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .row        (row),
        .col        (col),
        .key_value  (key_value),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key k = r*4+c shorts row r to column c; a row reads low only while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_phase = 0; m_col = 0; m_row = 0; m_streak = 0;
        m_value = 4'h0; m_valid = 1'b0; m_pressed = 1'b0;
        hist.delete();
        hist.push_back(4'hF);
        hist.push_back(4'hF);
    endtask

    task automatic model_edge(input logic [3:0] rv, input logic rst_low);
        logic [3:0] rs;
        if (rst_low) begin
            model_reset();
            return;
        end
        rs = hist[0];
        m_valid = 1'b0;
        if ((m_cyc % ScanDiv) == ScanDiv - 1) begin
            m_ticks++;
            case (m_phase)
                0: begin
                    if (rs == 4'hF) begin
                        m_col = (m_col + 1) % 4;
                    end else begin
                        for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
                        m_streak = 0;
                        m_phase  = 1;
                    end
                end
                1: begin
                    if (!rs[m_row]) begin
                        m_streak++;
                        if (m_streak == Debounce) begin
                            m_phase   = 2;
                            m_value   = 4'(m_row * 4 + m_col);
                            m_valid   = 1'b1;
                            m_pressed = 1'b1;
                        end
                    end else begin
                        m_phase = 0;
                        m_col   = (m_col + 1) % 4;
                    end
                end
                2: begin
                    if (rs[m_row]) begin
                        m_streak = 0;
                        m_phase  = 3;
                    end
                end
                default: begin
                    if (rs[m_row]) begin
                        m_streak++;
                        if (m_streak == Debounce) begin
                            m_phase   = 0;
                            m_pressed = 1'b0;
                            m_col     = (m_col + 1) % 4;
                        end
                    end else begin
                        m_phase = 2;
                    end
                end
            endcase
        end
        m_cyc++;
        void'(hist.pop_front());
        hist.push_back(rv);
    endtask

    // One clock: capture row, clock DUT and model, compare all outputs at the falling edge.
    task automatic step();
        logic [3:0] rv;
        logic [3:0] one;
        #1;
        rv = row;
        @(posedge clk);
        model_edge(rv, !reset_n);
        @(negedge clk);
        if (key_valid) vcount++;
        one = 4'b0001;
        chk("col", {4'h0, col}, {4'h0, ~(one << m_col)});
        chk("key_valid", {7'h0, key_valid}, {7'h0, m_valid});
        chk("key_pressed", {7'h0, key_pressed}, {7'h0, m_pressed});
        chk("key_value", {4'h0, key_value}, {4'h0, m_value});
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = m_ticks + n;
        while (m_ticks < target) step();
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         seen;
        int         v0;
        int         t;
        int         k;
        logic [3:0] one;
        one     = 4'b0001;
        keys    = 16'h0;
        m_ticks = 0;
        model_reset();

        // Reset state, asserted asynchronously before any clock edge.
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_col", {4'h0, col}, 8'h0E);
        chk("rst_valid", {7'h0, key_valid}, 8'h00);
        chk("rst_pressed", {7'h0, key_pressed}, 8'h00);
        chk("rst_value", {4'h0, key_value}, 8'h00);
        repeat (3) step();
        reset_n = 1'b1;

        // Idle scan: column advances every ScanDiv clocks from column 0.
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("idle_col", {4'h0, col}, {4'h0, ~(one << ((n / ScanDiv) % 4))});
            chk("idle_valid", {7'h0, key_valid}, 8'h00);
        end

        // Key 9 (row 2, col 1): single accept, held without repeats.
        v0 = vcount;
        keys[9] = 1'b1;
        wait_valid(200, seen);
        chk("press9_seen", {7'h0, seen}, 8'h01);
        chk("press9_value", {4'h0, key_value}, 8'h09);
        chk("press9_pressed", {7'h0, key_pressed}, 8'h01);
        repeat (60) step();
        chk("press9_single", 8'(vcount - v0), 8'h01);
        chk("press9_held", {7'h0, key_pressed}, 8'h01);

        // Bouncy release of key 9.
        wait_ticks(1);
        keys[9] = 1'b0;
        wait_ticks(1);
        keys[9] = 1'b1;
        wait_ticks(1);
        keys[9] = 1'b0;
        chk("bounce_pressed", {7'h0, key_pressed}, 8'h01);
        wait_ticks(2);
        chk("release_early", {7'h0, key_pressed}, 8'h01);
        t = 0;
        while (key_pressed && t < 6) begin
            wait_ticks(1);
            t++;
        end
        chk("release_fell", {7'h0, key_pressed}, 8'h00);
        chk("release_value", {4'h0, key_value}, 8'h09);
        chk("release_no_valid", 8'(vcount - v0), 8'h01);

        // One-tick glitch on row 0 during column 3.
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (col == 4'b0111) seen = 1'b1;
        end
        chk("glitch_col3", {7'h0, seen}, 8'h01);
        v0 = vcount;
        keys[3] = 1'b1;
        wait_ticks(1);
        keys[3] = 1'b0;
        wait_ticks(1);
        chk("glitch_resume", {4'h0, col}, 8'h0E);
        chk("glitch_value", {4'h0, key_value}, 8'h09);
        chk("glitch_no_valid", 8'(vcount - v0), 8'h00);

        // Rows 1 and 3 together in column 2: lowest row wins.
        v0 = vcount;
        keys[6]  = 1'b1;
        keys[14] = 1'b1;
        wait_valid(200, seen);
        chk("dual_seen", {7'h0, seen}, 8'h01);
        chk("dual_value", {4'h0, key_value}, 8'h06);
        repeat (40) step();
        chk("dual_single", 8'(vcount - v0), 8'h01);
        chk("dual_held", {7'h0, key_pressed}, 8'h01);

        // Reset while holding: immediate, no clock edge needed.
        #2 reset_n = 1'b0;
        #1;
        chk("hold_rst_col", {4'h0, col}, 8'h0E);
        chk("hold_rst_pressed", {7'h0, key_pressed}, 8'h00);
        chk("hold_rst_valid", {7'h0, key_valid}, 8'h00);
        chk("hold_rst_value", {4'h0, key_value}, 8'h00);
        keys = 16'h0;
        repeat (2) step();
        reset_n = 1'b1;

        // Randomised presses, releases and occasional chords against the model.
        for (int it = 0; it < 30; it++) begin
            keys = 16'h0;
            k = $urandom_range(0, 15);
            keys[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 15);
                keys[k] = 1'b1;
            end
            repeat ($urandom_range(1, 60)) step();
            keys = 16'h0;
            repeat ($urandom_range(1, 60)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_4x4.md
KEYPAD_SCAN_4X4 -- requirements
Module: keypad_scan_4x4

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per scan tick (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive agreeing ticks needed to accept a press or a release (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, pulled up externally; low means the key at the driven column is pressed.
REQ-006 The block SHALL have port col, output, 4 bits: active-low one-hot column drive.
REQ-007 The block SHALL have port key_value, output, 4 bits: code of the last accepted key.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a new key is accepted.
REQ-009 The block SHALL have port key_pressed, output, 1 bit: level, high while an accepted key is held.

Function
REQ-010 The block SHALL pass row through a 2-flop synchronizer; all decisions SHALL use the synchronized value row_s.
REQ-011 A divider SHALL count 0..SCAN_DIV-1 and wrap; "tick" SHALL be the cycle in which it equals SCAN_DIV-1. Sampling SHALL occur only on ticks.
REQ-012 col SHALL equal ~(4'b0001 << col_idx), where col_idx is 2 bits and increments modulo 4 (3 wraps to 0).
REQ-013 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-014 SCAN, on a tick with row_s == 4'b1111: col_idx SHALL advance by 1 and the state SHALL remain SCAN.
REQ-015 SCAN, on a tick with row_s != 4'b1111: the block SHALL latch row_idx = the lowest index of a zero bit (priority to row 0), hold col_idx, clear db_cnt, and go to DEBOUNCE.
REQ-016 DEBOUNCE, on a tick with row_s[row_idx] == 0: when db_cnt == DEBOUNCE-1 the state SHALL go to HOLD; otherwise db_cnt SHALL increment.
REQ-017 DEBOUNCE, on a tick with row_s[row_idx] == 1: the state SHALL return to SCAN, col_idx SHALL advance, and no output SHALL change.
REQ-018 On the DEBOUNCE->HOLD transition, key_value SHALL become {row_idx, col_idx} (row*4+col), key_valid SHALL be high for exactly the next single clk cycle, and key_pressed SHALL go high in the same cycle.
REQ-019 HOLD, on a tick with row_s[row_idx] == 1: the block SHALL clear db_cnt and go to RELEASE. Other row bits SHALL be ignored, and no further key_valid SHALL fire while in HOLD.
REQ-020 RELEASE, on a tick with row_s[row_idx] == 1: when db_cnt == DEBOUNCE-1 the block SHALL go to SCAN, drive key_pressed low, and advance col_idx; otherwise db_cnt SHALL increment.
REQ-021 RELEASE, on a tick with row_s[row_idx] == 0: the state SHALL return to HOLD, with key_pressed still high and no new key_valid.
REQ-022 key_value SHALL hold its value until the next accepted key and SHALL be unaffected by release.
REQ-023 Keys pressed in other columns while in DEBOUNCE, HOLD or RELEASE SHALL be ignored; only one key is tracked at a time.
REQ-024 Latency from the first tick that sees a stable press to the key_valid pulse SHALL be DEBOUNCE ticks, plus 1 clk for the registered output.
REQ-025 All outputs SHALL be registered, with no combinational path from row to any output.

Reset
REQ-026 While reset_n is low, the block SHALL hold: state=SCAN, col_idx=0 (col=4'b1110), divider=0, db_cnt=0, synchronizer flops=4'b1111, key_value=4'h0, key_valid=0, key_pressed=0.
REQ-027 Reset asserted in any state, mid-debounce or mid-hold, SHALL take effect immediately and discard the tracked key.
REQ-028 After reset_n deasserts, scanning SHALL restart from column 0 and the first tick SHALL occur SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-029 The bench SHALL apply idle rows (4'b1111) for 40 cycles and check that col cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every 4 clk, with no key_valid.
REQ-030 The bench SHALL model the key at row 2, col 1 (row[2] low only when col==4'b1101), hold it, and check one key_valid pulse, key_value=4'h9, key_pressed=1, and no second pulse while held.
REQ-031 The bench SHALL apply a glitch: row 0 low for 1 tick during column 3 scan, then high; check no key_valid, key_value unchanged, and scanning resumes at column 0.
REQ-032 The bench SHALL release key 4'h9 after acceptance, bouncing once (high 1 tick, low 1 tick, then high), and check key_pressed stays 1 through the bounce, falls only after 3 stable-high ticks, and no extra key_valid occurs.
REQ-033 The bench SHALL press row 1 and row 3 simultaneously in column 2 and check key_value=4'h6 (lowest row wins) with a single key_valid.
REQ-034 The bench SHALL assert reset_n=0 while in HOLD and check that col=4'b1110, key_pressed=0, key_valid=0 and key_value=4'h0 immediately, with no clock edge required.
